elevator_request_scheduler: RTL

Collects floor calls for a single car, latches them as pending requests and sequences the elevator controller one target floor at a time using a collective up/down (SCAN) policy. Sits upstream of the elevator controller. It drives the controller's `request_floor` and consumes its `complete` indication and the OR of its timer and weight alerts. Serves calls in travel order and holds dispatch while a fault is present.

---
 rtl/elevator_request_scheduler.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/elevator_request_scheduler.sv
// elevator_request_scheduler
//
// Latches floor calls for a single car and hands the elevator controller one
// target floor at a time, serving calls in travel order (collective SCAN).
// Dispatch is held off while the controller reports a fault.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   call_req       per-floor call strobes, latched into pending
//   current_floor  car position reported by the controller
//   complete       controller reached request_floor (used only in DISPATCH)
//   fault          OR of controller timer/weight alerts, level-sensitive
//   request_floor  target floor to the controller
//   dispatch_valid request_floor is a live command
//   pending        outstanding calls
//   sched_dir      scan direction, 1 = up, 0 = down
//   busy           not idle, or calls outstanding
module elevator_request_scheduler #(
    parameter int unsigned NUM_FLOORS   = 8,
    parameter int unsigned DWELL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [2:0]            current_floor,
    input  logic                  complete,
    input  logic                  fault,
    output logic [2:0]            request_floor,
    output logic                  dispatch_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  sched_dir,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StDispatch, StDwell, StHold} state_e;

    state_e                  state_q;
    logic [7:0]              cnt_q;
    logic [NUM_FLOORS-1:0]   pending_q;
    logic [NUM_FLOORS-1:0]   pending_d;
    logic [2:0]              request_floor_q;
    logic                    dispatch_valid_q;
    logic                    sched_dir_q;
    logic                    busy_q;

    // Pending bits widened to the 3-bit floor address space; unused floors read 0.
    logic [7:0] pend8, call8, clr8, pend_next8;
    logic       cur_ok, here;
    logic       above_any, below_any, rt_up_any, rt_dn_any;
    logic [2:0] above_lo, below_hi, rt_up, rt_dn;
    logic       tgt_any, tgt_dir;
    logic [2:0] tgt;
    logic       to_idle;

    assign pend8  = 8'(pending_q);
    assign call8  = 8'(call_req);
    assign cur_ok = 32'(current_floor) < NUM_FLOORS;
    assign here   = pend8[current_floor];

    // Nearest pending floors relative to the car and to the current target.
    always_comb begin
        above_any = 1'b0;
        above_lo  = '0;
        below_any = 1'b0;
        below_hi  = '0;
        rt_up_any = 1'b0;
        rt_up     = '0;
        rt_dn_any = 1'b0;
        rt_dn     = '0;
        // Descending scan: the last hit is the lowest qualifying floor.
        for (int i = 7; i >= 0; i--) begin
            if (pend8[i] && (i > int'(current_floor))) begin
                above_any = 1'b1;
                above_lo  = 3'(i);
                if (i < int'(request_floor_q)) begin
                    rt_up_any = 1'b1;
                    rt_up     = 3'(i);
                end
            end
        end
        // Ascending scan: the last hit is the highest qualifying floor.
        for (int i = 0; i < 8; i++) begin
            if (pend8[i] && (i < int'(current_floor))) begin
                below_any = 1'b1;
                below_hi  = 3'(i);
                if (i > int'(request_floor_q)) begin
                    rt_dn_any = 1'b1;
                    rt_dn     = 3'(i);
                end
            end
        end
    end

    // SCAN choice from IDLE: keep direction while calls remain ahead, else reverse.
    always_comb begin
        tgt_any = above_any || below_any;
        tgt_dir = sched_dir_q;
        tgt     = '0;
        if (sched_dir_q) begin
            if (above_any) begin
                tgt = above_lo;
            end else if (below_any) begin
                tgt     = below_hi;
                tgt_dir = 1'b0;
            end
        end else begin
            if (below_any) begin
                tgt = below_hi;
            end else if (above_any) begin
                tgt     = above_lo;
                tgt_dir = 1'b1;
            end
        end
    end

    // Served-floor clear mask and next-state-is-IDLE flag (feeds busy).
    always_comb begin
        clr8    = '0;
        to_idle = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fault) begin
                    if (!cur_ok)       to_idle = 1'b1;
                    else if (here)     clr8    = 8'b1 << current_floor;
                    else if (!tgt_any) to_idle = 1'b1;
                end
            end
            StDispatch: begin
                if (!fault && complete) clr8 = 8'b1 << request_floor_q;
            end
            StDwell: begin
                if (!fault && (cnt_q == 8'd0)) to_idle = 1'b1;
            end
            StHold: begin
                if (!fault) to_idle = 1'b1;
            end
            default: ;
        endcase
    end

    // Clear wins over a same-edge call for the same floor.
    assign pend_next8 = (pend8 | call8) & ~clr8;
    assign pending_d  = pend_next8[NUM_FLOORS-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            pending_q        <= '0;
            request_floor_q  <= '0;
            dispatch_valid_q <= 1'b0;
            sched_dir_q      <= 1'b1;
            busy_q           <= 1'b0;
        end else begin
            pending_q <= pending_d;
            busy_q    <= !to_idle || (|pending_d);
            unique case (state_q)
                StIdle: begin
                    if (fault) begin
                        state_q <= StHold;
                    end else if (cur_ok) begin
                        if (here) begin
                            state_q <= StDwell;
                            cnt_q   <= 8'(DWELL_CYCLES - 1);
                        end else if (tgt_any) begin
                            request_floor_q  <= tgt;
                            sched_dir_q      <= tgt_dir;
                            dispatch_valid_q <= 1'b1;
                            state_q          <= StDispatch;
                        end
                    end
                end
                StDispatch: begin
                    if (fault) begin
                        dispatch_valid_q <= 1'b0;
                        state_q          <= StHold;
                    end else if (complete) begin
                        dispatch_valid_q <= 1'b0;
                        state_q          <= StDwell;
                        cnt_q            <= 8'(DWELL_CYCLES - 1);
                    end else if (sched_dir_q && rt_up_any) begin
                        request_floor_q <= rt_up;
                    end else if (!sched_dir_q && rt_dn_any) begin
                        request_floor_q <= rt_dn;
                    end
                end
                StDwell: begin
                    if (fault)                  state_q <= StHold;
                    else if (cnt_q == 8'd0)     state_q <= StIdle;
                    else                        cnt_q   <= cnt_q - 8'd1;
                end
                StHold: begin
                    dispatch_valid_q <= 1'b0;
                    if (!fault) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign request_floor  = request_floor_q;
    assign dispatch_valid = dispatch_valid_q;
    assign pending        = pending_q;
    assign sched_dir      = sched_dir_q;
    assign busy           = busy_q;

endmodule
